// File: rtl/xotr_phase_sequencer.sv
// ---------------------------------------------------------------------------
// xotr_phase_sequencer
// Upstream stage of the ED-prefix (XOTR) opcode decoder. This block holds all
// of the decoder's state: the XPT execution-phase counter, the XOTR-mode latch
// and the captured opcode byte. Keeping that state here lets the downstream
// decoder stay purely combinational. Every output comes from a register, so
// each output changes exactly one edge after the input that causes it.
//
// Ports
//   i_CLK               system clock, rising edge
//   i_notRESET          asynchronous active-low reset
//   i_Set_XOTR          ED prefix fetched; enter XOTR mode on the next edge
//   i_Reset_XOTR        end-of-instruction strobe from the decoder; leave XOTR mode
//   i_Reset_XPT         end-of-instruction strobe from the decoder; restart the phase count
//   i_Wait              bus wait state; XPT is frozen while this is high
//   i_Load_Source       opcode fetch is complete; capture i_Dt_In
//   i_Dt_In             data bus byte
//   o_XPT / o_notXPT    current phase and its complement (separate register)
//   o_Source/o_notSource captured opcode and its complement (separate register)
//   o_not_enable        0 while XOTR mode is active (decoder enabled)
//   o_Phase_Start       one-cycle pulse: XPT restarted at 0 this cycle
//   o_Err_XPT_Overrun   sticky; set when an increment is requested at the max phase
// ---------------------------------------------------------------------------
// state   | meaning
// ST_IDLE | not in XOTR mode, so the decoder is disabled (o_not_enable = 1)
// ST_XOTR | an ED prefix was seen, so the decoder is enabled (o_not_enable = 0)
// ---------------------------------------------------------------------------
module xotr_phase_sequencer #(
    parameter int                 XPT_W   = 5,
    parameter int                 SRC_W   = 8,
    parameter logic [SRC_W-1:0]   SRC_RST = 8'h00
) (
    input  logic               i_CLK,
    input  logic               i_notRESET,
    input  logic               i_Set_XOTR,
    input  logic               i_Reset_XOTR,
    input  logic               i_Reset_XPT,
    input  logic               i_Wait,
    input  logic               i_Load_Source,
    input  logic [SRC_W-1:0]   i_Dt_In,
    output logic [XPT_W-1:0]   o_XPT,
    output logic [XPT_W-1:0]   o_notXPT,
    output logic [SRC_W-1:0]   o_Source,
    output logic [SRC_W-1:0]   o_notSource,
    output logic               o_not_enable,
    output logic               o_Phase_Start,
    output logic               o_Err_XPT_Overrun
);

    localparam logic [XPT_W-1:0] XPT_MAX = '1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XOTR = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [XPT_W-1:0]   r_xpt;
    logic [XPT_W-1:0]   r_not_xpt;
    logic [XPT_W-1:0]   w_xpt_nxt;
    logic [SRC_W-1:0]   r_source;
    logic [SRC_W-1:0]   r_not_source;
    logic               r_phase_start;
    logic               w_phase_start_nxt;
    logic               r_err;
    logic               w_err_nxt;

    // XOTR latch. Set beats Reset, so chained ED ED prefixes stay in XOTR mode.
    always_comb begin
        w_state_nxt = r_state;
        if (i_Set_XOTR)
            w_state_nxt = ST_XOTR;
        else if (i_Reset_XOTR)
            w_state_nxt = ST_IDLE;
    end

    // Phase counter, in priority order: restart, wait, saturate, increment.
    always_comb begin
        w_xpt_nxt         = r_xpt;
        w_phase_start_nxt = 1'b0;
        w_err_nxt         = r_err;
        if (i_Reset_XPT) begin
            w_xpt_nxt         = '0;
            w_phase_start_nxt = 1'b1;
            w_err_nxt         = 1'b0;
        end else if (i_Wait) begin
            w_xpt_nxt = r_xpt;
        end else if (r_xpt == XPT_MAX) begin
            w_err_nxt = 1'b1;
        end else begin
            w_xpt_nxt = r_xpt + 1'b1;
        end
    end

    always_ff @(posedge i_CLK or negedge i_notRESET) begin
        if (!i_notRESET) begin
            r_state       <= ST_IDLE;
            r_xpt         <= '0;
            r_not_xpt     <= '1;
            r_phase_start <= 1'b0;
            r_err         <= 1'b0;
            r_source      <= SRC_RST;
            r_not_source  <= ~SRC_RST;
        end else begin
            r_state       <= w_state_nxt;
            r_xpt         <= w_xpt_nxt;
            // The complements get their own flops so the decoder sees true and
            // inverted buses with matched timing; they track by construction.
            r_not_xpt     <= ~w_xpt_nxt;
            r_phase_start <= w_phase_start_nxt;
            r_err         <= w_err_nxt;
            if (i_Load_Source) begin
                r_source     <= i_Dt_In;
                r_not_source <= ~i_Dt_In;
            end
        end
    end

    assign o_XPT             = r_xpt;
    assign o_notXPT          = r_not_xpt;
    assign o_Source          = r_source;
    assign o_notSource       = r_not_source;
    assign o_not_enable      = (r_state == ST_IDLE);
    assign o_Phase_Start     = r_phase_start;
    assign o_Err_XPT_Overrun = r_err;

endmodule
